// File: rtl/tinyqv_periph_bus_ctrl_pkg.sv
// Shared types and constants for the tinyQV peripheral bus controller.
package tinyqv_periph_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_DONE    = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

  localparam logic [1:0]  SIZE_NONE = 2'b11;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // Anything outside the bottom 32 MB of the 28-bit space belongs to the peripherals.
  function automatic logic is_periph_region(input logic [27:0] addr);
    return (addr[27:25] != 3'b000);
  endfunction

endpackage

// File: rtl/tinyqv_periph_bus_ctrl_if.sv
// CPU-side and peripheral-side signals of the bus controller; master = controller view.
interface tinyqv_periph_bus_ctrl_if #(
  parameter int NUM_PERIPH = 8,
  parameter int SLOT_LSB   = 6
);
  logic [27:0]              data_addr;
  logic [1:0]               data_write_n;
  logic [1:0]               data_read_n;
  logic                     data_read_complete;
  logic [31:0]              data_out;
  logic                     data_ready;
  logic [31:0]              data_in;
  logic [NUM_PERIPH-1:0]    periph_sel;
  logic [SLOT_LSB-1:0]      periph_addr;
  logic [1:0]               periph_write_n;
  logic [1:0]               periph_read_n;
  logic [31:0]              periph_wdata;
  logic                     periph_read_complete;
  logic [NUM_PERIPH*32-1:0] periph_rdata;
  logic [NUM_PERIPH-1:0]    periph_ready;
  logic                     bus_error;
  logic                     err_clear;

  modport master (
    input  data_addr, data_write_n, data_read_n, data_read_complete, data_out,
           periph_rdata, periph_ready, err_clear,
    output data_ready, data_in, periph_sel, periph_addr, periph_write_n,
           periph_read_n, periph_wdata, periph_read_complete, bus_error
  );

  modport slave (
    output data_addr, data_write_n, data_read_n, data_read_complete, data_out,
           periph_rdata, periph_ready, err_clear,
    input  data_ready, data_in, periph_sel, periph_addr, periph_write_n,
           periph_read_n, periph_wdata, periph_read_complete, bus_error
  );
endinterface

// File: rtl/tinyqv_periph_bus_ctrl_timeout.sv
// Access watchdog for the peripheral bus; exists only when TINYQV_PERIPH_TIMEOUT_EN is defined.
`ifdef TINYQV_PERIPH_TIMEOUT_EN
module tinyqv_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  // Counter is held at zero outside ACCESS so every access starts a fresh window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= 8'd0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_count && (r_cnt == LAST_CNT);
endmodule
`endif

// File: rtl/tinyqv_periph_bus_ctrl.sv
// Sequences CPU non-memory transactions onto one-hot peripheral slots.
// Optional access timeout enabled by defining TINYQV_PERIPH_TIMEOUT_EN.
module tinyqv_periph_bus_ctrl
  import tinyqv_periph_bus_ctrl_pkg::*;
#(
  parameter int NUM_PERIPH     = 8,
  parameter int SLOT_LSB       = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rstn,
  tinyqv_periph_bus_ctrl_if.master bus
);

  state_t                r_state;
  logic                  r_ready;
  logic [31:0]           r_data_in;
  logic [NUM_PERIPH-1:0] r_sel;
  logic [SLOT_LSB-1:0]   r_addr;
  logic [1:0]            r_write_n;
  logic [1:0]            r_read_n;
  logic [31:0]           r_wdata;
  logic                  r_rd_cmpl;
  logic                  r_bus_error;

  logic [3:0]            w_slot;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_req;
  logic                  w_mapped;
  logic [NUM_PERIPH-1:0] w_onehot;
  logic                  w_sel_ready;
  logic [31:0]           w_sel_rdata;
  logic                  w_expire;
  logic                  w_err_set;
  logic                  w_unused_addr;

  assign w_slot        = bus.data_addr[SLOT_LSB+3:SLOT_LSB];
  assign w_wr          = (bus.data_write_n != SIZE_NONE);
  assign w_rd          = (bus.data_read_n != SIZE_NONE);
  assign w_req         = (w_wr || w_rd) && is_periph_region(bus.data_addr);
  assign w_mapped      = (int'(w_slot) < NUM_PERIPH);
  assign w_sel_ready   = |(bus.periph_ready & r_sel);
  assign w_unused_addr = ^bus.data_addr[24:SLOT_LSB+4];

  // Slot decode and read-data mux keyed on the registered select, so foreign ready/data is ignored.
  always_comb begin
    w_onehot    = {NUM_PERIPH{1'b0}};
    w_sel_rdata = 32'h0000_0000;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      w_onehot[k] = (w_slot == 4'(k));
      w_sel_rdata = w_sel_rdata | (bus.periph_rdata[32*k +: 32] & {32{r_sel[k]}});
    end
  end

`ifdef TINYQV_PERIPH_TIMEOUT_EN
  tinyqv_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (r_state != ST_ACCESS),
    .i_count  (r_state == ST_ACCESS),
    .o_expire (w_expire)
  );
`else
  logic [7:0] w_unused_tmo;
  assign w_unused_tmo = 8'(TIMEOUT_CYCLES);
  assign w_expire     = 1'b0;
`endif

  // Error sources: request to an unmapped slot, or an access that timed out without ready.
  always_comb begin
    w_err_set = 1'b0;
    if ((r_state == ST_IDLE) && w_req && !w_mapped) begin
      w_err_set = 1'b1;
    end else if ((r_state == ST_ACCESS) && !w_sel_ready && w_expire) begin
      w_err_set = 1'b1;
    end else begin
      w_err_set = 1'b0;
    end
  end

  // Transaction FSM with all bus outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_data_in   <= 32'h0000_0000;
      r_sel       <= {NUM_PERIPH{1'b0}};
      r_addr      <= {SLOT_LSB{1'b0}};
      r_write_n   <= SIZE_NONE;
      r_read_n    <= SIZE_NONE;
      r_wdata     <= 32'h0000_0000;
      r_rd_cmpl   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_rd_cmpl <= bus.data_read_complete;
      r_ready   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.data_addr[SLOT_LSB-1:0];
            r_wdata <= bus.data_out;
            if (w_mapped) begin
              r_sel     <= w_onehot;
              r_write_n <= bus.data_write_n;
              r_read_n  <= w_wr ? SIZE_NONE : bus.data_read_n;
              r_state   <= ST_ACCESS;
            end else begin
              r_data_in <= 32'h0000_0000;
              r_ready   <= 1'b1;
              r_state   <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            r_data_in <= (r_write_n != SIZE_NONE) ? 32'h0000_0000 : w_sel_rdata;
            r_sel     <= {NUM_PERIPH{1'b0}};
            r_write_n <= SIZE_NONE;
            r_read_n  <= SIZE_NONE;
            r_ready   <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_expire) begin
            r_data_in <= ERR_RDATA;
            r_sel     <= {NUM_PERIPH{1'b0}};
            r_write_n <= SIZE_NONE;
            r_read_n  <= SIZE_NONE;
            r_ready   <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold here until the CPU drops its request so a held strobe is not re-issued.
          if (!w_wr && !w_rd) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RELEASE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_err_set) begin
        r_bus_error <= 1'b1;
      end else if (bus.err_clear) begin
        r_bus_error <= 1'b0;
      end else begin
        r_bus_error <= r_bus_error;
      end
    end
  end

  assign bus.data_ready           = r_ready;
  assign bus.data_in              = r_data_in;
  assign bus.periph_sel           = r_sel;
  assign bus.periph_addr          = r_addr;
  assign bus.periph_write_n       = r_write_n;
  assign bus.periph_read_n        = r_read_n;
  assign bus.periph_wdata         = r_wdata;
  assign bus.periph_read_complete = r_rd_cmpl;
  assign bus.bus_error            = r_bus_error;

endmodule

// File: tb/tb_tinyqv_periph_bus_ctrl.sv
// Directed self-checking bench for tinyqv_periph_bus_ctrl (NUM_PERIPH=8, SLOT_LSB=6).
// Builds with or without TINYQV_PERIPH_TIMEOUT_EN; the timeout step follows the macro.
module tb_tinyqv_periph_bus_ctrl;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;
  int   n_rdy;
  int   n_acc;
  int   base_rdy;
  int   base_acc;
  logic [7:0] prev_sel;

  tinyqv_periph_bus_ctrl_if #(.NUM_PERIPH(8), .SLOT_LSB(6)) bus ();

  tinyqv_periph_bus_ctrl #(
    .NUM_PERIPH     (8),
    .SLOT_LSB       (6),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses and fresh slot selections away from the active edge.
  initial begin
    n_rdy = 0;
    n_acc = 0;
    prev_sel = 8'h00;
  end
  always @(negedge clk) begin
    if (bus.data_ready === 1'b1) n_rdy++;
    if ((bus.periph_sel != 8'h00) && (prev_sel == 8'h00)) n_acc++;
    prev_sel = bus.periph_sel;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    bus.data_addr          = 28'h000_0000;
    bus.data_write_n       = 2'b11;
    bus.data_read_n        = 2'b11;
    bus.data_read_complete = 1'b0;
    bus.data_out           = 32'h0000_0000;
    bus.periph_rdata       = {8{32'h0000_0000}};
    bus.periph_ready       = 8'h00;
    bus.err_clear          = 1'b0;

    // Reset values
    step(3);
    chk("rst_ready", 32'(bus.data_ready), 32'h0);
    chk("rst_data_in", bus.data_in, 32'h0);
    chk("rst_sel", 32'(bus.periph_sel), 32'h0);
    chk("rst_addr", 32'(bus.periph_addr), 32'h0);
    chk("rst_write_n", 32'(bus.periph_write_n), 32'h3);
    chk("rst_read_n", 32'(bus.periph_read_n), 32'h3);
    chk("rst_wdata", bus.periph_wdata, 32'h0);
    chk("rst_rdcmpl", 32'(bus.periph_read_complete), 32'h0);
    chk("rst_err", 32'(bus.bus_error), 32'h0);
    rstn = 1'b1;
    step(1);

    // 32-bit write, slot 1 offset 8, ready two cycles after select
    base_rdy = n_rdy;
    base_acc = n_acc;
    bus.data_addr    = 28'h800_0048;
    bus.data_out     = 32'h1234_5678;
    bus.data_write_n = 2'b10;
    step(1);
    chk("wr_sel", 32'(bus.periph_sel), 32'h2);
    chk("wr_write_n", 32'(bus.periph_write_n), 32'h2);
    chk("wr_read_n", 32'(bus.periph_read_n), 32'h3);
    chk("wr_addr", 32'(bus.periph_addr), 32'h8);
    chk("wr_wdata", bus.periph_wdata, 32'h1234_5678);
    step(1);
    chk("wr_wait_ready", 32'(bus.data_ready), 32'h0);
    chk("wr_wait_sel", 32'(bus.periph_sel), 32'h2);
    bus.periph_ready = 8'b0000_0010;
    step(1);
    chk("wr_done_ready", 32'(bus.data_ready), 32'h1);
    chk("wr_done_data", bus.data_in, 32'h0);
    chk("wr_done_sel", 32'(bus.periph_sel), 32'h0);
    chk("wr_done_write_n", 32'(bus.periph_write_n), 32'h3);
    chk("wr_done_err", 32'(bus.bus_error), 32'h0);
    bus.periph_ready = 8'h00;
    idle_req();
    step(1);
    chk("wr_pulse_end", 32'(bus.data_ready), 32'h0);
    step(1);
    chk("wr_n_ready", 32'(n_rdy - base_rdy), 32'h1);
    chk("wr_n_access", 32'(n_acc - base_acc), 32'h1);

    // 8-bit read slot 3 offset 5, ready already high: data_ready two edges after request
    base_rdy = n_rdy;
    base_acc = n_acc;
    bus.periph_rdata[3*32 +: 32] = 32'h0000_00A5;
    bus.periph_rdata[1*32 +: 32] = 32'hDEAD_BEEF;
    bus.periph_ready = 8'b0000_1000;
    bus.data_addr    = 28'h800_00C5;
    bus.data_read_n  = 2'b00;
    step(1);
    chk("rd_sel", 32'(bus.periph_sel), 32'h8);
    chk("rd_read_n", 32'(bus.periph_read_n), 32'h0);
    chk("rd_addr", 32'(bus.periph_addr), 32'h5);
    chk("rd_not_yet", 32'(bus.data_ready), 32'h0);
    step(1);
    chk("rd_ready", 32'(bus.data_ready), 32'h1);
    chk("rd_data", bus.data_in, 32'h0000_00A5);
    bus.periph_ready = 8'h00;

    // Same read request held five more cycles: no re-issue
    step(5);
    chk("hold_sel", 32'(bus.periph_sel), 32'h0);
    chk("hold_data_in", bus.data_in, 32'h0000_00A5);
    idle_req();
    step(2);
    chk("hold_n_ready", 32'(n_rdy - base_rdy), 32'h1);
    chk("hold_n_access", 32'(n_acc - base_acc), 32'h1);

    // Write and read together on slot 0: write wins; request dropped mid-access
    bus.periph_rdata[0 +: 32] = 32'h1111_1111;
    bus.periph_ready  = 8'b0000_0001;
    bus.data_addr     = 28'h800_0003;
    bus.data_out      = 32'h0000_00AB;
    bus.data_write_n  = 2'b00;
    bus.data_read_n   = 2'b00;
    step(1);
    chk("wr_rd_sel", 32'(bus.periph_sel), 32'h1);
    chk("wr_rd_write_n", 32'(bus.periph_write_n), 32'h0);
    chk("wr_rd_read_n", 32'(bus.periph_read_n), 32'h3);
    chk("wr_rd_wdata", bus.periph_wdata, 32'h0000_00AB);
    idle_req();
    bus.data_read_complete = 1'b1;
    step(1);
    chk("wr_rd_ready", 32'(bus.data_ready), 32'h1);
    chk("wr_rd_data_in", bus.data_in, 32'h0);
    chk("rdcmpl_fwd", 32'(bus.periph_read_complete), 32'h1);
    bus.data_read_complete = 1'b0;
    bus.periph_ready = 8'h00;
    step(1);
    chk("rdcmpl_drop", 32'(bus.periph_read_complete), 32'h0);
    step(1);

    // 16-bit read slot 2: ready from other slots ignored
    bus.periph_rdata[2*32 +: 32] = 32'h0000_BEEF;
    bus.periph_ready = 8'b1111_1011;
    bus.data_addr    = 28'h800_0090;
    bus.data_read_n  = 2'b01;
    step(1);
    chk("rd16_sel", 32'(bus.periph_sel), 32'h4);
    chk("rd16_read_n", 32'(bus.periph_read_n), 32'h1);
    chk("rd16_addr", 32'(bus.periph_addr), 32'h10);
    step(1);
    chk("rd16_foreign_ready", 32'(bus.data_ready), 32'h0);
    bus.periph_ready = 8'b0000_0100;
    step(1);
    chk("rd16_ready", 32'(bus.data_ready), 32'h1);
    chk("rd16_data", bus.data_in, 32'h0000_BEEF);
    bus.periph_ready = 8'h00;
    idle_req();
    step(2);

    // Unmapped slot 12: immediate completion, zero data, sticky error
    bus.data_addr   = 28'h800_0300;
    bus.data_read_n = 2'b10;
    step(1);
    chk("unmap_ready", 32'(bus.data_ready), 32'h1);
    chk("unmap_sel", 32'(bus.periph_sel), 32'h0);
    chk("unmap_data", bus.data_in, 32'h0);
    chk("unmap_err", 32'(bus.bus_error), 32'h1);
    chk("unmap_read_n", 32'(bus.periph_read_n), 32'h3);
    idle_req();
    step(1);
    chk("err_sticky", 32'(bus.bus_error), 32'h1);
    bus.err_clear = 1'b1;
    step(1);
    chk("err_cleared", 32'(bus.bus_error), 32'h0);
    bus.err_clear = 1'b0;

    // Memory-region address never reaches the peripherals
    base_rdy = n_rdy;
    bus.data_addr    = 28'h000_0048;
    bus.data_write_n = 2'b10;
    step(3);
    chk("mem_sel", 32'(bus.periph_sel), 32'h0);
    chk("mem_n_ready", 32'(n_rdy - base_rdy), 32'h0);
    idle_req();
    step(1);

    // Slot 2 never ready
    bus.data_addr   = 28'h800_0080;
    bus.data_read_n = 2'b10;
`ifdef TINYQV_PERIPH_TIMEOUT_EN
    step(1);
    chk("tmo_sel", 32'(bus.periph_sel), 32'h4);
    step(14);
    chk("tmo_not_yet", 32'(bus.data_ready), 32'h0);
    step(1);
    chk("tmo_ready", 32'(bus.data_ready), 32'h1);
    chk("tmo_data", bus.data_in, 32'hFFFF_FFFF);
    chk("tmo_err", 32'(bus.bus_error), 32'h1);
    chk("tmo_sel_drop", 32'(bus.periph_sel), 32'h0);
    idle_req();
    step(2);
    bus.err_clear = 1'b1;
    step(1);
    chk("tmo_err_clear", 32'(bus.bus_error), 32'h0);
    bus.err_clear   = 1'b0;
    bus.data_read_n = 2'b10;
    step(2);
`else
    base_rdy = n_rdy;
    step(100);
    chk("wait_sel", 32'(bus.periph_sel), 32'h4);
    chk("wait_ready", 32'(bus.data_ready), 32'h0);
    chk("wait_err", 32'(bus.bus_error), 32'h0);
    chk("wait_n_ready", 32'(n_rdy - base_rdy), 32'h0);
`endif

    // Reset asserted mid-access, then a ready pulse
    chk("pre_rst_read_n", 32'(bus.periph_read_n), 32'h2);
    base_rdy = n_rdy;
    rstn = 1'b0;
    #1;
    chk("arst_sel", 32'(bus.periph_sel), 32'h0);
    chk("arst_read_n", 32'(bus.periph_read_n), 32'h3);
    chk("arst_addr", 32'(bus.periph_addr), 32'h0);
    chk("arst_data_in", bus.data_in, 32'h0);
    bus.periph_ready = 8'b0000_0100;
    step(1);
    bus.periph_ready = 8'h00;
    step(1);
    chk("arst_ready", 32'(bus.data_ready), 32'h0);
    chk("arst_n_ready", 32'(n_rdy - base_rdy), 32'h0);
    chk("arst_err", 32'(bus.bus_error), 32'h0);
    idle_req();
    rstn = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
